muldiv_seq: RTL

//  Parametrised iterative multiply/divide sequencer; successor to the fixed 32-bit microcoded multiply path.

---
 rtl/muldiv_seq.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide sequencer beside execute.
//   One radix-2 step per cycle over WIDTH cycles. Fetch is stalled while iterating.
//   The unit returns the result, the remainder, the destination index and the merged flags.
// Ports:
//   clk, rst                   clock and asynchronous active-high reset
//   start, op, set_flags       launch request, operation (00 MULU lo, 01 MULU hi, 10 MULS hi, 11 DIVU) and flag-update enable
//   src_a, src_b               multiplicand/dividend and multiplier/divisor
//   dest_in, flags_in          destination register index and current flags, latched at start
//   abort                      flushes the operation in flight
//   busy, stall, done          status outputs; done is a one-cycle completion pulse
//   dest_out, result,
//   remainder, flags_out       registered completion outputs, held until the next completion
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; operands are latched on the start edge
// RUN   | one shift-add or restoring-divide step per edge
// DONE  | done pulse; completion outputs are valid
module muldiv_seq #(
  parameter int WIDTH  = 32,
  parameter int FLAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic              set_flags,
  input  logic [WIDTH-1:0]  src_a,
  input  logic [WIDTH-1:0]  src_b,
  input  logic [3:0]        dest_in,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic              abort,
  output logic              busy,
  output logic              stall,
  output logic              done,
  output logic [3:0]        dest_out,
  output logic [WIDTH-1:0]  result,
  output logic [WIDTH-1:0]  remainder,
  output logic [FLAG_W-1:0] flags_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] OP_MULU_LO = 2'b00;
  localparam logic [1:0] OP_MULS_HI = 2'b10;
  localparam logic [1:0] OP_DIVU    = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT              state;
  logic [CW-1:0]      count;
  logic [1:0]         opReg;
  logic               setFlagsReg;
  logic [FLAG_W-1:0]  flagsReg;
  logic [3:0]         destReg;
  logic               negProd;
  logic [WIDTH-1:0]   mcand;     // multiplicand magnitude, or divisor for DIVU
  logic [2*WIDTH-1:0] acc;       // {high half, multiplier} for MUL; {partial remainder, dividend/quotient} for DIVU

  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulAcc;
  logic [WIDTH:0]     divTrial;
  logic               divGe;
  logic [WIDTH-1:0]   divRem;
  logic [2*WIDTH-1:0] divAcc;
  logic [2*WIDTH-1:0] stepAcc;
  logic [2*WIDTH-1:0] finalProd;
  logic [WIDTH-1:0]   finalResult;
  logic [WIDTH-1:0]   finalRem;
  logic [FLAG_W-1:0]  finalFlags;
  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic [FLAG_W-1:0]  divZeroFlags;
  logic               divZero;

  always_comb begin
    // Shift-add: the carry out of the high half becomes the new MSB after the right shift.
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    mulAcc   = {mulSum, acc[WIDTH-1:1]};
    // Restoring divide: shift {rem, quo} left, subtract if it fits, shift the quotient bit in.
    divTrial = acc[2*WIDTH-1:WIDTH-1];
    divGe    = divTrial >= {1'b0, mcand};
    divRem   = divGe ? (divTrial[WIDTH-1:0] - mcand) : divTrial[WIDTH-1:0];
    divAcc   = {divRem, acc[WIDTH-2:0], divGe};
    stepAcc  = (opReg == OP_DIVU) ? divAcc : mulAcc;

    finalProd = negProd ? ('0 - stepAcc) : stepAcc;
    case (opReg)
      OP_MULU_LO: finalResult = finalProd[WIDTH-1:0];
      OP_DIVU:    finalResult = stepAcc[WIDTH-1:0];
      default:    finalResult = finalProd[2*WIDTH-1:WIDTH];
    endcase
    finalRem = (opReg == OP_DIVU) ? stepAcc[2*WIDTH-1:WIDTH] : '0;

    finalFlags = flagsReg;
    if (setFlagsReg) begin
      finalFlags    = '0;
      finalFlags[3] = finalResult[WIDTH-1];
      finalFlags[2] = (finalResult == '0);
      finalFlags[1] = (opReg == OP_MULU_LO) && (finalProd[2*WIDTH-1:WIDTH] != '0);
      finalFlags[0] = 1'b0;
    end

    // Magnitudes of the signed operands fit in WIDTH unsigned bits, including -2^(WIDTH-1).
    absA = src_a[WIDTH-1] ? ('0 - src_a) : src_a;
    absB = src_b[WIDTH-1] ? ('0 - src_b) : src_b;

    divZero = (op == OP_DIVU) && (src_b == '0);
    divZeroFlags = flags_in;
    if (set_flags) begin
      divZeroFlags    = '0;
      divZeroFlags[3] = 1'b1;
      divZeroFlags[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      opReg       <= '0;
      setFlagsReg <= 1'b0;
      flagsReg    <= '0;
      destReg     <= '0;
      negProd     <= 1'b0;
      mcand       <= '0;
      acc         <= '0;
      busy        <= 1'b0;
      stall       <= 1'b0;
      done        <= 1'b0;
      dest_out    <= '0;
      result      <= '0;
      remainder   <= '0;
      flags_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opReg       <= op;
            setFlagsReg <= set_flags;
            flagsReg    <= flags_in;
            destReg     <= dest_in;
            count       <= '0;
            negProd     <= (op == OP_MULS_HI) && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            busy        <= 1'b1;
            if (op == OP_MULS_HI) begin
              mcand <= absA;
              acc   <= {{WIDTH{1'b0}}, absB};
            end else if (op == OP_DIVU) begin
              mcand <= src_b;
              acc   <= {{WIDTH{1'b0}}, src_a};
            end else begin
              mcand <= src_a;
              acc   <= {{WIDTH{1'b0}}, src_b};
            end
            if (divZero) begin
              state     <= DONE;
              done      <= 1'b1;
              dest_out  <= dest_in;
              result    <= '1;
              remainder <= src_a;
              flags_out <= divZeroFlags;
            end else begin
              state <= RUN;
              stall <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            stall <= 1'b0;
          end else begin
            acc   <= stepAcc;
            count <= count + 1'b1;
            if (count == CW'(WIDTH - 1)) begin
              state     <= DONE;
              stall     <= 1'b0;
              done      <= 1'b1;
              dest_out  <= destReg;
              result    <= finalResult;
              remainder <= finalRem;
              flags_out <= finalFlags;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          stall <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
